// File: rtl/past_seq_pkg.sv
// Shared types and constants for the past-sequence decoder.
// Optional accepted-sample counter is enabled with PAST_SEQ_DEC_STATS_EN.
package past_seq_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_LOG_W = 2;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Window length W = 2**log_w.
  function automatic int unsigned win_len(input int unsigned log_w);
    return 32'd1 << log_w;
  endfunction

endpackage

// File: rtl/seq_hist_ring.sv
// W x DW circular history of decoded samples; read and write share one pointer.
// Entries have no reset: the parent zero-walks them after every flush.
module seq_hist_ring
  import past_seq_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LOG_W = DEF_LOG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ptr_rst,
  input  logic             i_we,
  input  logic [DW-1:0]    i_wdata,
  output logic [DW-1:0]    o_rdata,
  output logic [LOG_W-1:0] o_wptr
);

  localparam int unsigned W = win_len(LOG_W);

  logic [DW-1:0]    r_mem [W];
  logic [LOG_W-1:0] r_wptr;

  // Pointer restart has priority over a write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (i_ptr_rst) begin
      r_wptr <= '0;
    end else if (i_we) begin
      r_wptr <= r_wptr + LOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_we && !i_ptr_rst) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_wptr];
  assign o_wptr  = r_wptr;

endmodule

// File: rtl/past_sequence_decoder.sv
// Recovers samples x[n] = s[n] - s[n-1] + x[n-W] from a stream of W-wide window sums.
// Define PAST_SEQ_DEC_STATS_EN to add the 32-bit dec_count accepted-sample counter.
module past_sequence_decoder
  import past_seq_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LOG_W = DEF_LOG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          primed
`ifdef PAST_SEQ_DEC_STATS_EN
  ,
  output logic [31:0]   dec_count
`endif
);

  localparam int unsigned W  = win_len(LOG_W);
  localparam int unsigned CW = LOG_W + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [DW-1:0]    r_prev_sum;
  logic [DW-1:0]    r_out_data;
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic             r_primed;
  logic [DW-1:0]    w_hist_rd;
  logic [DW-1:0]    w_x;
  logic [DW-1:0]    w_ring_wdata;
  logic [LOG_W-1:0] w_wptr;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_ring_we;
  logic             w_fill_done;

  assign w_in_ready   = (r_state != ST_CLEAR) && !clear && (!r_out_valid || out_ready);
  assign w_accept     = in_valid && w_in_ready;
  assign w_x          = in_sum - r_prev_sum + w_hist_rd;
  assign w_fill_done  = (r_state == ST_FILL) && w_accept && (r_count == CW'(W - 1));
  assign w_ring_we    = (r_state == ST_CLEAR) || w_accept;
  assign w_ring_wdata = (r_state == ST_CLEAR) ? '0 : w_x;

  seq_hist_ring #(
    .DW    (DW),
    .LOG_W (LOG_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ptr_rst (clear),
    .i_we      (w_ring_we),
    .i_wdata   (w_ring_wdata),
    .o_rdata   (w_hist_rd),
    .o_wptr    (w_wptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_CLEAR: if (w_wptr == LOG_W'(W - 1)) w_state_nxt = ST_FILL;
      ST_FILL:  if (w_fill_done) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
    if (clear) w_state_nxt = ST_CLEAR;
  end

  // Output register, decode history and priming; clear discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_prev_sum  <= '0;
      r_count     <= '0;
      r_primed    <= 1'b0;
    end else begin
      r_primed <= (w_state_nxt == ST_RUN);
      if (clear) begin
        r_out_valid <= 1'b0;
        r_prev_sum  <= '0;
        r_count     <= '0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_x;
        r_prev_sum  <= in_sum;
        if (r_state == ST_FILL) r_count <= r_count + CW'(1);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef PAST_SEQ_DEC_STATS_EN
  logic [31:0] r_dec_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_count <= '0;
    end else if (clear) begin
      r_dec_count <= '0;
    end else if (w_accept) begin
      r_dec_count <= r_dec_count + 32'd1;
    end
  end

  assign dec_count = r_dec_count;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign primed    = r_primed;

endmodule

// File: doc/past_sequence_decoder.md
Name: past_sequence_decoder

Overview:
- Inverse of the windowed past-sequence adder. Takes a stream of window sums s[n] = x[n] + x[n-1] + ... + x[n-W+1], with W = 2**LOG_W, and recovers the original samples.
- Recurrence: x[n] = s[n] - s[n-1] + x[n-W].
- Sits on the receive side of the summed-sample link. Valid/ready on both ends, one output register.

Parameters:
- DW, 8: sample and sum width; all arithmetic is modulo 2**DW.
- LOG_W, 2: log2 of the window length W; legal range 1..8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous history flush request, single-cycle pulse
- in_valid  in  1  in_sum is valid
- in_ready  out  1  decoder accepts in_sum this cycle
- in_sum  in  DW  window sum s[n]
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DW  recovered sample x[n]
- primed  out  1  W samples decoded since the last flush

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, primed=0.
  - prev_sum=0, wptr=0, count=0.
  - State goes to CLEAR.
- State machine CLEAR -> FILL -> RUN:
  - CLEAR: writes 0 to hist[wptr] each cycle and increments wptr. After W cycles (wptr wraps to 0) it moves to FILL. in_ready=0 throughout. The ring has no reset, so CLEAR is the only initialiser.
  - FILL: normal decoding. count increments per accepted sample; on reaching W it moves to RUN.
  - RUN: normal decoding, primed=1.
- Handshake:
  - in_ready = (state != CLEAR) && !clear && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - out_valid holds, with out_data stable, until out_ready is sampled high.
  - Accept with out_valid && out_ready in the same cycle: the old word leaves and the new one loads, so full throughput is 1 sample/clk.
- Decode on accept (all updates registered):
  - x = in_sum - prev_sum + hist[wptr], computed modulo 2**DW (wrap, no saturation).
  - out_data <= x, out_valid <= 1.
  - hist[wptr] <= x, wptr <= wptr + 1 mod W, prev_sum <= in_sum.
- Latency: 1 clk from accept to out_valid.
- Output drain: a cycle with out_ready=1 and no accept clears out_valid.
- Clear (synchronous):
  - out_valid <= 0 (pending word is discarded).
  - prev_sum <= 0, count <= 0, primed <= 0, wptr <= 0.
  - State goes to CLEAR, re-zeroing all W entries over W cycles.
- Clear coincident with in_valid: clear wins and the sample is not accepted (in_ready is 0 that cycle).
- Clear asserted while already in CLEAR: the walk restarts from wptr=0.
- out_ready while out_valid=0: ignored.
- The decoder is exact for any stream produced by the adder from an all-zero history, including wrapped sums.

Optional Feature:
- Macro: PAST_SEQ_DEC_STATS_EN.
- Defined:
  - Extra output port dec_count, 32 bits: counts accepted samples.
  - Resets to 0 on rst_n and on clear.
  - Wraps at 2**32.
- Undefined:
  - Port and counter absent; all other behaviour identical.

Decomposition:
- Package past_seq_pkg:
  - state enum {CLEAR, FILL, RUN}.
  - Helper constant W = 2**LOG_W.
  - Default DW.
- Sub-module seq_hist_ring:
  - W x DW circular history with wptr, read-at-wptr and write-at-wptr.
  - Zero-walk driven by the parent FSM.
- Decode arithmetic, handshake and FSM stay in past_sequence_decoder.

Test Plan (DW=8, LOG_W=2):
- Reset release: in_ready=0 for exactly 4 clks after rst_n rises, then 1; out_valid=0, primed=0.
- Sums 1,3,6,10,14,18 (x=1..6), out_ready=1 -> out_data 1,2,3,4,5,6, one per clk; primed rises after the 4th output.
- Wrap: sums 200,44,144 (x=200,100,100) -> out_data 200,100,100.
- Backpressure: out_ready=0 for 3 clks with the 2nd sample pending -> in_ready=0 and out_data stays 2 until out_ready=1; no sample is lost or duplicated.
- Clear after 2 samples -> out_valid drops, in_ready=0 for 4 clks; then sums 7,9 -> out_data 7,2, since the history was re-zeroed.
- Async reset mid-stream with out_valid=1 -> out_valid=0 immediately; the CLEAR walk repeats and decoding restarts from a zero history.
